// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer: slot-state encodings, default widths
// and the per-slot record held by the top level.
package sb_pkg;

  localparam int DEF_SB_SIZE = 5;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_ALLOC  = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  typedef struct packed {
    logic [1:0]            state;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sb_slot_t;

  // A slot can forward once its address and data are known.
  function automatic logic slot_fwd_ok(input logic [1:0] st);
    return (st == ST_READY) || (st == ST_COMMIT);
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Age-ordered store-to-load match: the youngest READY/COMMIT slot whose
// address equals the load address supplies the forwarded data.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int SB_SIZE  = DEF_SB_SIZE,
  parameter int SB_DEPTH = 2 ** SB_SIZE,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic [SB_SIZE-1:0] i_head,
  input  logic [SB_SIZE-1:0] i_tail,
  input  sb_slot_t           i_slot [SB_DEPTH],
  input  logic [ADDR_W-1:0]  i_ld_addr,
  output logic               o_hit,
  output logic [DATA_W-1:0]  o_data
);

  logic [SB_SIZE-1:0] w_span;
  logic [SB_SIZE-1:0] w_idx;

  assign w_span = i_tail - i_head;

  // Walk oldest to youngest from the head so the last hit is the youngest.
  // A zero span means empty or full; an empty buffer has no forwardable slot.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = i_head;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_idx = i_head + SB_SIZE'(k);
      if (((w_span == '0) || (SB_SIZE'(k) < w_span)) &&
          slot_fwd_ok(i_slot[w_idx].state) &&
          (i_slot[w_idx].addr == i_ld_addr)) begin
        o_hit  = 1'b1;
        o_data = i_slot[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order circular store buffer: dual allocation at dispatch, LSU fill,
// in-order commit from the ROB, oldest-first drain to memory, load forwarding.
module store_buffer
  import sb_pkg::*;
#(
  parameter int SB_SIZE  = DEF_SB_SIZE,
  parameter int SB_DEPTH = 2 ** SB_SIZE,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Flush,
  input  logic               Alloc1_V,
  input  logic               Alloc2_V,
  output logic [SB_SIZE-1:0] SB_Addr1,
  output logic [SB_SIZE-1:0] SB_Addr2,
  output logic               SB_stall,
  input  logic               LSU_SB_V,
  input  logic [SB_SIZE-1:0] LSU_SB_Index,
  input  logic [ADDR_W-1:0]  LSU_SB_Addr,
  input  logic [DATA_W-1:0]  LSU_SB_Data,
  input  logic               ROB_Retire1_SB_V,
  input  logic [SB_SIZE-1:0] ROB_Retire1_SB_Addr,
  input  logic               ROB_Retire2_SB_V,
  input  logic [SB_SIZE-1:0] ROB_Retire2_SB_Addr,
  output logic               Mem_Wr_V,
  output logic [ADDR_W-1:0]  Mem_Wr_Addr,
  output logic [DATA_W-1:0]  Mem_Wr_Data,
  input  logic               Mem_Wr_Ready,
  input  logic [ADDR_W-1:0]  Ld_Addr,
  output logic               Ld_Hit,
  output logic [DATA_W-1:0]  Ld_Data,
  output logic               SB_Err
);

  localparam logic [SB_SIZE:0]   DEPTH_N = (SB_SIZE+1)'(SB_DEPTH);
  localparam logic [SB_SIZE:0]   TWO_N   = (SB_SIZE+1)'(2);
  localparam logic [SB_SIZE:0]   ONE_N   = (SB_SIZE+1)'(1);
  localparam logic [SB_SIZE-1:0] ONE_P   = SB_SIZE'(1);

  sb_slot_t           r_slot [SB_DEPTH];
  logic [SB_SIZE-1:0] r_head;
  logic [SB_SIZE-1:0] r_tail;
  logic [SB_SIZE-1:0] r_cptr;
  logic [SB_SIZE:0]   r_count;
  logic               r_err;

  logic               w_do_alloc1;
  logic               w_do_alloc2;
  logic [SB_SIZE:0]   w_alloc_n;
  logic               w_drain_fire;
  logic               w_ret1_ok;
  logic               w_ret2_ok;
  logic [SB_SIZE-1:0] w_cptr_mid;
  logic [SB_SIZE-1:0] w_cptr_nxt;
  logic               w_lsu_ok;
  logic               w_lsu_err;
  logic               w_err_set;
  logic [1:0]         w_state_nxt [SB_DEPTH];
  logic [SB_SIZE:0]   w_ncommit;

  assign SB_Addr1 = r_tail;
  assign SB_Addr2 = Alloc1_V ? (r_tail + ONE_P) : r_tail;
  assign SB_stall = (DEPTH_N - r_count) < TWO_N;

  // A flushing cycle drops dispatch and LSU traffic outright, without error.
  assign w_do_alloc1 = Alloc1_V & ~SB_stall & ~Flush;
  assign w_do_alloc2 = Alloc2_V & ~SB_stall & ~Flush;
  assign w_alloc_n   = (SB_SIZE+1)'(w_do_alloc1) + (SB_SIZE+1)'(w_do_alloc2);

  assign Mem_Wr_V     = (r_slot[r_head].state == ST_COMMIT);
  assign Mem_Wr_Addr  = r_slot[r_head].addr;
  assign Mem_Wr_Data  = r_slot[r_head].data;
  assign w_drain_fire = Mem_Wr_V & Mem_Wr_Ready;

  // Retire2 is checked against the commit pointer as already moved by Retire1.
  assign w_ret1_ok  = ROB_Retire1_SB_V && (ROB_Retire1_SB_Addr == r_cptr) &&
                      (r_slot[r_cptr].state == ST_READY);
  assign w_cptr_mid = r_cptr + SB_SIZE'(w_ret1_ok);
  assign w_ret2_ok  = ROB_Retire2_SB_V && (ROB_Retire2_SB_Addr == w_cptr_mid) &&
                      (r_slot[w_cptr_mid].state == ST_READY);
  assign w_cptr_nxt = w_cptr_mid + SB_SIZE'(w_ret2_ok);

  assign w_lsu_ok  = LSU_SB_V && !Flush && (r_slot[LSU_SB_Index].state == ST_ALLOC);
  assign w_lsu_err = LSU_SB_V && !Flush && (r_slot[LSU_SB_Index].state != ST_ALLOC);
  assign w_err_set = w_lsu_err || (ROB_Retire1_SB_V && !w_ret1_ok) ||
                     (ROB_Retire2_SB_V && !w_ret2_ok);

  // Every check above uses the pre-edge slot states; the flush sweep runs last
  // so same-cycle retires survive as COMMIT.
  always_comb begin
    for (int i = 0; i < SB_DEPTH; i++) w_state_nxt[i] = r_slot[i].state;
    if (w_drain_fire) w_state_nxt[r_head]       = ST_FREE;
    if (w_ret1_ok)    w_state_nxt[r_cptr]       = ST_COMMIT;
    if (w_ret2_ok)    w_state_nxt[w_cptr_mid]   = ST_COMMIT;
    if (w_lsu_ok)     w_state_nxt[LSU_SB_Index] = ST_READY;
    if (w_do_alloc1)  w_state_nxt[r_tail]       = ST_ALLOC;
    if (w_do_alloc2)  w_state_nxt[SB_Addr2]     = ST_ALLOC;
    if (Flush) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if ((w_state_nxt[i] == ST_ALLOC) || (w_state_nxt[i] == ST_READY))
          w_state_nxt[i] = ST_FREE;
      end
    end
  end

  always_comb begin
    w_ncommit = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (w_state_nxt[i] == ST_COMMIT) w_ncommit = w_ncommit + ONE_N;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SB_DEPTH; i++) r_slot[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_cptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) r_slot[i].state <= w_state_nxt[i];
      if (w_lsu_ok) begin
        r_slot[LSU_SB_Index].addr <= LSU_SB_Addr;
        r_slot[LSU_SB_Index].data <= LSU_SB_Data;
      end
      r_head  <= r_head + SB_SIZE'(w_drain_fire);
      r_cptr  <= w_cptr_nxt;
      r_tail  <= Flush ? w_cptr_nxt : (r_tail + w_alloc_n[SB_SIZE-1:0]);
      r_count <= Flush ? w_ncommit
                       : (r_count + w_alloc_n - (SB_SIZE+1)'(w_drain_fire));
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign SB_Err = r_err;

  sb_fwd_match #(
    .SB_SIZE  (SB_SIZE),
    .SB_DEPTH (SB_DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_fwd (
    .i_head    (r_head),
    .i_tail    (r_tail),
    .i_slot    (r_slot),
    .i_ld_addr (Ld_Addr),
    .o_hit     (Ld_Hit),
    .o_data    (Ld_Data)
  );

endmodule
